// File: rtl/relu_maxpool2x2_layer1_if.sv
// relu_maxpool2x2_layer1_if: feature-map stream in (data_in/valid_in) and pooled stream out (data_out/valid_out/frame_done)
interface relu_maxpool2x2_layer1_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  frame_done;
  modport master (output data_in, valid_in, input data_out, valid_out, frame_done);
  modport slave (input data_in, valid_in, output data_out, valid_out, frame_done);
endinterface

// File: rtl/relu_maxpool2x2_layer1.sv
// relu_maxpool2x2_layer1: ReLU + 2x2/2 max pool of a raster fp32 stream; ports clk, rst (sync high), bus (slave: data_in/valid_in in, data_out/valid_out/frame_done out)
module relu_maxpool2x2_layer1 #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  relu_maxpool2x2_layer1_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;
  localparam int LW = (HW > 1) ? $clog2(HW) : 1;
  logic [CW-1:0] r_col, r_row;
  logic [DATA_WIDTH-1:0] r_pair, r_data_out;
  logic [DATA_WIDTH-1:0] r_line [HW];
  logic r_valid_out, r_frame_done;
  logic [LW-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_r, w_h, w_lb, w_m;
  logic w_last_col, w_last_row;
  assign w_idx = LW'(r_col >> 1);
  assign w_r = bus.data_in[DATA_WIDTH-1] ? '0 : bus.data_in;
  assign w_h = (w_r > r_pair) ? w_r : r_pair;
  assign w_lb = r_line[w_idx];
  assign w_m = (w_h > w_lb) ? w_h : w_lb;
  assign w_last_col = r_col == CW'(WIDTH - 1);
  assign w_last_row = r_row == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (bus.valid_in && r_col[0] && !r_row[0]) r_line[w_idx] <= w_h;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_pair <= '0;
      r_data_out <= '0;
      r_valid_out <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.valid_in) begin
        if (!r_col[0]) r_pair <= w_r;
        if (r_col[0] && r_row[0]) begin
          r_data_out <= w_m;
          r_valid_out <= 1'b1;
          r_frame_done <= w_last_col && w_last_row;
        end
        r_col <= w_last_col ? '0 : r_col + CW'(1);
        if (w_last_col) r_row <= w_last_row ? '0 : r_row + CW'(1);
      end
    end
  end
  assign bus.data_out = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.frame_done = r_frame_done;
endmodule

// File: doc/relu_maxpool2x2_layer1.md
Name: relu_maxpool2x2_layer1

Overview:
- Downstream stage of featuremap_conv2d_0_filter0.
- Consumes that block's single-filter 32-bit IEEE-754 feature-map stream: raster order, WIDTH x WIDTH, qualified by valid.
- Applies ReLU, then 2x2 stride-2 max pooling.
- Emits a (WIDTH/2) x (WIDTH/2) raster stream to the next layer. One instance per filter.

Parameters:
- DATA_WIDTH, 32, sample width. IEEE-754 single only; other values unsupported.
- WIDTH, 32, input feature-map side length. Must be even and >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  conv output sample (featuremap data_out).
- valid_in  input  1  data_in valid this cycle (featuremap valid_out).
- data_out  output  DATA_WIDTH  pooled sample, ReLU-clamped.
- valid_out  output  1  data_out valid; single-cycle pulse per pooled sample.
- frame_done  output  1  one-cycle pulse coincident with the last pooled sample of a frame.

Behaviour:
- Reset (rst=1 at a clk edge) clears col, row, pair register, data_out, valid_out and frame_done to 0. Line buffer contents are don't-care.
- Reset mid-frame abandons the frame. The first valid_in after reset is pixel (0,0).
- No backpressure. Every valid_in=1 cycle consumes one sample. valid_in gaps of any length are legal, and state holds during gaps.
- ReLU: r = (data_in[31]==1) ? 32'h0 : data_in. This covers -0, negatives and negative NaN.
- After ReLU all values are non-negative, so max is an unsigned 32-bit compare. Ties keep the earlier operand (bitwise identical anyway). Positive NaN/Inf compare as large unsigned and win.
- Counters:
  - col counts 0..WIDTH-1; row counts 0..WIDTH-1. Both advance only on valid_in.
  - col wraps to 0 and row increments at col=WIDTH-1.
  - Both wrap to 0 after (WIDTH-1, WIDTH-1); the next frame starts with no idle cycle required.
- Pair register: on even col, store r into pair_reg. On odd col, h = max(pair_reg, r).
- Line buffer: WIDTH/2 entries x DATA_WIDTH, single write port, single read port, indexed by col>>1.
  - Even row, odd col: write h to line_buf[col>>1]. No output.
  - Odd row, odd col: m = max(line_buf[col>>1], h). Register m to data_out and pulse valid_out.
  - Read and write never target the same entry in the same cycle. Registered-read or LUT RAM implementations are both acceptable, provided the latency below holds.
- Latency: valid_out asserts exactly 1 cycle after the accepting edge of the odd-row, odd-col input. data_out holds its last value when valid_out=0.
- Output count: exactly (WIDTH/2)^2 valid_out pulses per frame, in raster order of the pooled map.
- frame_done pulses in the same cycle as the valid_out for the input at (WIDTH-1, WIDTH-1).
- Outputs are produced only for odd-row, odd-col inputs, so consecutive valid_out pulses are separated by at least one cycle.
- Simultaneous rst and valid_in: rst wins and the sample is discarded.

Test Plan:
- WIDTH=4 frame of values 1.0..16.0 (32'h3F800000 onward, raster), valid_in continuous -> 4 outputs 6.0, 8.0, 14.0, 16.0 (32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000). Each appears 1 cycle after inputs 5, 7, 13, 15 (0-based). frame_done with the 16.0 output.
- WIDTH=4 frame with every sample negative (e.g. 32'hBF800000) plus one 32'h80000000 -> all 4 outputs 32'h00000000. A window mixing -5.0 and 0.5 outputs 32'h3F000000.
- Default WIDTH=32, random valid_in duty ~50%, 1024 random floats -> 256 outputs matching a reference ReLU+maxpool model bit-exactly, and exactly one frame_done.
- Two back-to-back WIDTH=4 frames with no gap -> 8 outputs. Second-frame results are independent of the first (first frame all 100.0, second frame all 1.0, second outputs 1.0).
- Assert rst for one cycle after 9 inputs of a WIDTH=4 frame, then send a full fresh frame -> no output from the aborted frame after reset. The fresh frame yields 4 correct outputs; valid_out and data_out are 0 in the cycle after reset.
- Positive NaN 32'h7FC00000 in one window -> that output is 32'h7FC00000; the other windows are unaffected.
